// File: rtl/ex_divider.sv
// ex_divider: iterative 32-bit integer divider for the LA32R EX stage.
// Implements div.w / mod.w / div.wu / mod.wu with one restoring step
// per cycle.
//
// Handshake: EX raises `start` with valid forwarded operands. The
// divider samples `start` only in IDLE and holds `busy` while it
// computes. It then pulses `done` for one cycle with `result` valid.
// `flush` aborts the operation from any state with no `done`.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               divide request (sampled in IDLE only)
//   op[1:0]             00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//   src0, src1          dividend, divisor
//   flush               pipeline flush, aborts any operation
//   busy                stall request (CALC and FIX)
//   done                one-cycle result strobe (DONE state)
//   result[31:0]        quotient or remainder, held until the next done
//
// Build option DIV_ZERO_FAST_EN: a zero divisor goes straight from IDLE
// to DONE without running the iterations.
module ex_divider #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [32:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          neg_q;
  logic          neg_r;
  logic          fix_ph;

  // Operand conditioning for the accept cycle.
  logic        sgn_op, a_neg, b_neg, zero_fast;
  logic [31:0] a_mag, b_mag;

  assign sgn_op = ~op[1];
  assign a_neg  = sgn_op & src0[31];
  assign b_neg  = sgn_op & src1[31];
  assign a_mag  = a_neg ? (32'd0 - src0) : src0;
  assign b_mag  = b_neg ? (32'd0 - src1) : src1;

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (src1 == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  // Restoring step. rem never exceeds the divisor, so rem[32] is always
  // zero; it is kept in the trial so the subtraction stays exact.
  logic [33:0] trial;
  logic        trial_ok;

  assign trial    = {rem, quo[31]} - {2'b00, dvs};
  assign trial_ok = ~trial[33];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_fast ? DONE : CALC;
      CALC: if (cnt == CW'(ITER - 1)) state_nxt = FIX;
      FIX:  if (fix_ph) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Output decode, purely from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. FIX spends two cycles: the first applies signs to the
  // quotient/remainder, the second registers the selected value into
  // result together with the transition into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      fix_ph <= 1'b0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          rem    <= '0;
          quo    <= a_mag;
          dvs    <= b_mag;
          cnt    <= '0;
          fix_ph <= 1'b0;
          if (zero_fast) result <= op[0] ? src0 : 32'hFFFF_FFFF;
        end
        CALC: begin
          rem <= trial_ok ? trial[32:0] : {rem[31:0], quo[31]};
          quo <= {quo[30:0], trial_ok};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!fix_ph) begin
            quo    <= neg_q ? (32'd0 - quo) : quo;
            rem    <= {1'b0, neg_r ? (32'd0 - rem[31:0]) : rem[31:0]};
            fix_ph <= 1'b1;
          end else begin
            result <= op_q[0] ? rem[31:0] : quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ex_divider.md
# ex_divider

Iterative 32-bit integer divider in the EX stage of the five-stage LA32R pipeline. It consumes the forwarded operands selected by the EX-stage operand muxes and implements div.w, mod.w, div.wu and mod.wu. It holds `busy` so the hazard/stall logic freezes IF/ID/EX and inserts a bubble into MEM while a division runs. It returns a 32-bit result that the EX/MEM register captures on the `done` cycle.

## Interface
- `ITER`, default 32: number of quotient-bit iterations; fixed at 32 for LA32R.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: EX holds a divide op with operands valid (after forwarding); sampled only in IDLE.
- `op` input 2: operation code.
  - 00 div.w
  - 01 mod.w
  - 10 div.wu
  - 11 mod.wu
- `src0` input 32: dividend, the forwarded rd0 value.
- `src1` input 32: divisor, the forwarded rd1 value.
- `flush` input 1: pipeline flush from a branch/exception; aborts any operation.
- `busy` output 1: stall request to pipeline control.
- `done` output 1: one-cycle pulse; `result` is valid this cycle.
- `result` output 32: quotient or remainder; holds its last value until the next `done`.

## Operation
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0. Reset mid-operation discards the operation with no `done`.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:** if `start`=1 and `flush`=0, latch `op` and the sign flags. Convert the operands to magnitudes for signed ops, or use them raw for unsigned ops. Clear the 33-bit partial remainder, set the iteration counter to 0, and go to CALC.
- **CALC:** one restoring step per cycle.
  - Shift {rem, quo} left by one.
  - Trial subtract the divisor magnitude from rem[32:0].
  - If the trial result is non-negative, keep it and set quo[0]=1.
  - After the 32nd step (counter=31), go to FIX.
- **FIX:** apply signs, then go to DONE.
  - Quotient is negated when the signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - Select quotient or remainder per `op` and register it into `result`.
- **DONE:** `done`=1 for exactly this cycle, then go to IDLE.
- **`busy`:** 1 in CALC and FIX, 0 in IDLE and DONE. The pipeline therefore advances on the DONE edge and captures `result`.
- **`flush`:** in any state, go to IDLE at the next edge. `done` is not asserted and `result` is unchanged. If `flush` and `start` are both high in IDLE, `flush` wins.
- **`start` while not IDLE:** ignored.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (32-bit wrap, no trap).
- **Divide by zero:** the result is defined as follows; no exception is raised.
  - Unsigned: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed with dividend ≥ 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed with dividend < 0: quotient 0x00000001, remainder = dividend.

## Timing
- Let edge k be the edge at which `start` is accepted.
- CALC runs over edges k+1 through k+32, FIX completes at edge k+33, and DONE is entered at edge k+34.
- `done`=1 during the cycle between edges k+34 and k+35.
- `busy`=1 between edges k and k+34, i.e. 34 cycles.
- Latency: 34 cycles from `start` to `done`. A new `start` can be accepted in the cycle after DONE.
- `busy` and `done` are registered state decodes, with no combinational path from `start` or `src*`.

## Configuration
- `DIV_ZERO_FAST_EN`
  - **Defined:** a zero divisor in IDLE goes directly to DONE. `result` is 0xFFFFFFFF for div and `src0` for mod, regardless of signedness. `done` is asserted in the cycle after acceptance and `busy` is never asserted.
  - **Undefined:** a zero divisor runs the full 34-cycle sequence and produces the divide-by-zero results listed under Operation.

## Test plan
- **Signed div/mod with a negative dividend:** div.w src0=0xFFFFFFF9 (−7), src1=2 → `result`=0xFFFFFFFD (−3), `done` at start+34. mod.w with the same operands → 0xFFFFFFFF (−1).
- **Unsigned division:** div.wu src0=0xFFFFFFF9, src1=2 → 0x7FFFFFFC. mod.wu → 0x00000001. `busy` is high for exactly 34 cycles.
- **Signed overflow:** div.w 0x80000000 / 0xFFFFFFFF → 0x80000000. mod.w → 0x00000000.
- **Divide by zero, macro off:** div.wu 0x1234 / 0 → 0xFFFFFFFF at start+34. div.w 0xFFFFFF00 / 0 → 0x00000001.
- **Divide by zero, macro on:** div.w 0x1234 / 0 → 0xFFFFFFFF at start+1 with `busy` never high. mod.w → 0x1234 at start+1.
- **Flush and reset mid-operation:**
  - `flush` at start+10 → IDLE next edge, no `done`, `result` unchanged.
  - `start` with `flush` in the same cycle → not accepted.
  - `rst` pulse at start+20 → all outputs 0.
  - A following div.w 100/7 → 14 at its own start+34.
